// File: rtl/decode_queue_if.sv
// Handshake bundle between fetch, decode_queue and execute.
// Defining RV_M_EXT_EN widens out_alu_op from 15 to 23 bits.
interface decode_queue_if #(
    parameter int XLEN = 64,
    parameter int PC_W = 64
);
`ifdef RV_M_EXT_EN
    localparam int ALU_W = 23;
`else
    localparam int ALU_W = 15;
`endif
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [PC_W-1:0]  in_pc;
    logic [31:0]      in_inst;
    logic             out_valid;
    logic             out_ready;
    logic [PC_W-1:0]  out_pc;
    logic [4:0]       out_rs1;
    logic [4:0]       out_rs2;
    logic [4:0]       out_rd;
    logic [XLEN-1:0]  out_imm;
    logic [1:0]       out_sel_src1;
    logic             out_sel_src2;
    logic [ALU_W-1:0] out_alu_op;
    logic [7:0]       out_bru_op;
    logic [6:0]       out_lsu_op;
    logic [1:0]       out_sel_rf_res;
    logic             out_rf_we;
    logic             out_illegal;

    modport master (
        output flush, in_valid, in_pc, in_inst, out_ready,
        input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm,
               out_sel_src1, out_sel_src2, out_alu_op, out_bru_op, out_lsu_op,
               out_sel_rf_res, out_rf_we, out_illegal
    );
    modport slave (
        input  flush, in_valid, in_pc, in_inst, out_ready,
        output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm,
               out_sel_src1, out_sel_src2, out_alu_op, out_bru_op, out_lsu_op,
               out_sel_rf_res, out_rf_we, out_illegal
    );
endinterface

// File: rtl/decode_queue.sv
// Instruction queue feeding a registered RV64I/RV32I decoder stage.
// Optional macro RV_M_EXT_EN adds M-extension decode on out_alu_op[22:15].
module decode_queue #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4,
    parameter int PC_W  = 64
) (
    input  logic          clock,
    input  logic          reset_n,
    decode_queue_if.slave bus
);
`ifdef RV_M_EXT_EN
    localparam int ALU_W = 23;
`else
    localparam int ALU_W = 15;
`endif
    localparam int AW = $clog2(DEPTH);
    // alu_op one-hot bit positions
    localparam int A_ADD = 0, A_SUB = 1, A_SLL = 2, A_SLT = 3, A_SLTU = 4;
    localparam int A_XOR = 5, A_SRL = 6, A_SRA = 7, A_OR = 8, A_AND = 9;
    localparam int A_ADDW = 10, A_SUBW = 11, A_SLLW = 12, A_SRLW = 13, A_SRAW = 14;
    localparam int A_MUL = 15;

    logic [PC_W-1:0] r_pc_q   [DEPTH];
    logic [31:0]     r_inst_q [DEPTH];
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [AW:0]     r_count;

    logic             r_out_valid, r_out_src2, r_out_we, r_out_ill;
    logic [PC_W-1:0]  r_out_pc;
    logic [4:0]       r_out_rs1, r_out_rs2, r_out_rd;
    logic [XLEN-1:0]  r_out_imm;
    logic [1:0]       r_out_src1, r_out_rfres;
    logic [ALU_W-1:0] r_out_alu;
    logic [7:0]       r_out_bru;
    logic [6:0]       r_out_lsu;

    logic w_push, w_pop;
    assign bus.in_ready = (r_count != (AW+1)'(DEPTH));
    assign w_push = bus.in_valid && bus.in_ready && !bus.flush;
    assign w_pop  = (r_count != '0) && (!r_out_valid || bus.out_ready) && !bus.flush;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_pc_q[r_wr_ptr]   <= bus.in_pc;
            r_inst_q[r_wr_ptr] <= bus.in_inst;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    logic [31:0]      w_inst;
    logic [6:0]       w_opc, w_f7;
    logic [2:0]       w_f3;
    logic [XLEN-1:0]  w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_shamt, w_shamt_w;
    logic             w_sh_lo, w_sh_ar;
    logic [XLEN-1:0]  w_imm;
    logic [1:0]       w_src1, w_rfres;
    logic             w_src2, w_we, w_ill;
    logic [ALU_W-1:0] w_alu;
    logic [7:0]       w_bru;
    logic [6:0]       w_lsu;

    assign w_inst    = r_inst_q[r_rd_ptr];
    assign w_opc     = w_inst[6:0];
    assign w_f3      = w_inst[14:12];
    assign w_f7      = w_inst[31:25];
    assign w_imm_i   = XLEN'($signed(w_inst[31:20]));
    assign w_imm_s   = XLEN'($signed({w_inst[31:25], w_inst[11:7]}));
    assign w_imm_b   = XLEN'($signed({w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0}));
    assign w_imm_u   = XLEN'($signed({w_inst[31:12], 12'b0}));
    assign w_imm_j   = XLEN'($signed({w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0}));
    assign w_shamt_w = XLEN'(w_inst[24:20]);
    // RV64 shifts borrow inst[25] as shamt[5]; RV32 requires it clear
    assign w_shamt   = (XLEN == 64) ? XLEN'(w_inst[25:20]) : w_shamt_w;
    assign w_sh_lo   = (XLEN == 64) ? (w_inst[31:26] == 6'b000000) : (w_f7 == 7'b0000000);
    assign w_sh_ar   = (XLEN == 64) ? (w_inst[31:26] == 6'b010000) : (w_f7 == 7'b0100000);

    always_comb begin
        w_imm = '0; w_src1 = '0; w_src2 = 1'b0; w_rfres = '0; w_we = 1'b0; w_ill = 1'b0;
        w_alu = '0; w_bru = '0; w_lsu = '0;
        case (w_opc)
            7'b0110111: begin w_alu[A_ADD] = 1'b1; w_src1 = 2'b10; w_src2 = 1'b1; w_imm = w_imm_u; w_we = 1'b1; end
            7'b0010111: begin w_alu[A_ADD] = 1'b1; w_src1 = 2'b01; w_src2 = 1'b1; w_imm = w_imm_u; w_we = 1'b1; end
            7'b1101111: begin w_bru[7] = 1'b1; w_imm = w_imm_j; w_rfres = 2'b01; w_we = 1'b1; end
            7'b1100111: begin
                w_bru[6] = 1'b1; w_imm = w_imm_i; w_rfres = 2'b01; w_we = 1'b1;
                if (w_f3 != 3'd0) w_ill = 1'b1;
            end
            7'b1100011: begin
                w_imm = w_imm_b;
                case (w_f3)
                    3'd0: w_bru[5] = 1'b1;
                    3'd1: w_bru[4] = 1'b1;
                    3'd4: w_bru[3] = 1'b1;
                    3'd5: w_bru[2] = 1'b1;
                    3'd6: w_bru[1] = 1'b1;
                    3'd7: w_bru[0] = 1'b1;
                    default: w_ill = 1'b1;
                endcase
            end
            7'b0000011: begin
                w_alu[A_ADD] = 1'b1; w_src2 = 1'b1; w_imm = w_imm_i; w_rfres = 2'b10; w_we = 1'b1;
                w_lsu = {1'b1, 1'b0, 4'b0001 << w_f3[1:0], w_f3[2]};
                if (w_f3 == 3'd7 || ((w_f3 == 3'd3 || w_f3 == 3'd6) && XLEN != 64)) w_ill = 1'b1;
            end
            7'b0100011: begin
                w_alu[A_ADD] = 1'b1; w_src2 = 1'b1; w_imm = w_imm_s;
                w_lsu = {1'b1, 1'b1, 4'b0001 << w_f3[1:0], 1'b0};
                if (w_f3[2] || (w_f3 == 3'd3 && XLEN != 64)) w_ill = 1'b1;
            end
            7'b0010011: begin
                w_src2 = 1'b1; w_imm = w_imm_i; w_we = 1'b1;
                case (w_f3)
                    3'd0: w_alu[A_ADD]  = 1'b1;
                    3'd2: w_alu[A_SLT]  = 1'b1;
                    3'd3: w_alu[A_SLTU] = 1'b1;
                    3'd4: w_alu[A_XOR]  = 1'b1;
                    3'd6: w_alu[A_OR]   = 1'b1;
                    3'd7: w_alu[A_AND]  = 1'b1;
                    3'd1: begin w_imm = w_shamt; w_alu[A_SLL] = 1'b1; w_ill = !w_sh_lo; end
                    default: begin
                        w_imm = w_shamt;
                        if (w_sh_lo)      w_alu[A_SRL] = 1'b1;
                        else if (w_sh_ar) w_alu[A_SRA] = 1'b1;
                        else              w_ill = 1'b1;
                    end
                endcase
            end
            7'b0011011: begin
                w_src2 = 1'b1; w_imm = w_imm_i; w_we = 1'b1; w_ill = (XLEN != 64);
                case (w_f3)
                    3'd0: w_alu[A_ADDW] = 1'b1;
                    3'd1: begin w_imm = w_shamt_w; w_alu[A_SLLW] = 1'b1; if (w_f7 != 7'b0) w_ill = 1'b1; end
                    3'd5: begin
                        w_imm = w_shamt_w;
                        if (w_f7 == 7'b0000000)      w_alu[A_SRLW] = 1'b1;
                        else if (w_f7 == 7'b0100000) w_alu[A_SRAW] = 1'b1;
                        else                         w_ill = 1'b1;
                    end
                    default: w_ill = 1'b1;
                endcase
            end
            7'b0110011: begin
                w_we = 1'b1;
                case (w_f7)
                    7'b0000000: case (w_f3)
                        3'd0: w_alu[A_ADD]  = 1'b1;
                        3'd1: w_alu[A_SLL]  = 1'b1;
                        3'd2: w_alu[A_SLT]  = 1'b1;
                        3'd3: w_alu[A_SLTU] = 1'b1;
                        3'd4: w_alu[A_XOR]  = 1'b1;
                        3'd5: w_alu[A_SRL]  = 1'b1;
                        3'd6: w_alu[A_OR]   = 1'b1;
                        default: w_alu[A_AND] = 1'b1;
                    endcase
                    7'b0100000: begin
                        if (w_f3 == 3'd0)      w_alu[A_SUB] = 1'b1;
                        else if (w_f3 == 3'd5) w_alu[A_SRA] = 1'b1;
                        else                   w_ill = 1'b1;
                    end
`ifdef RV_M_EXT_EN
                    7'b0000001: w_alu[A_MUL + int'(w_f3)] = 1'b1;
`endif
                    default: w_ill = 1'b1;
                endcase
            end
            7'b0111011: begin
                w_we = 1'b1; w_ill = (XLEN != 64);
                case (w_f7)
                    7'b0000000: case (w_f3)
                        3'd0: w_alu[A_ADDW] = 1'b1;
                        3'd1: w_alu[A_SLLW] = 1'b1;
                        3'd5: w_alu[A_SRLW] = 1'b1;
                        default: w_ill = 1'b1;
                    endcase
                    7'b0100000: begin
                        if (w_f3 == 3'd0)      w_alu[A_SUBW] = 1'b1;
                        else if (w_f3 == 3'd5) w_alu[A_SRAW] = 1'b1;
                        else                   w_ill = 1'b1;
                    end
`ifdef RV_M_EXT_EN
                    // mulw/divw/divuw/remw/remuw share the full-width op bits
                    7'b0000001: begin
                        if (w_f3 == 3'd1 || w_f3 == 3'd2 || w_f3 == 3'd3) w_ill = 1'b1;
                        else w_alu[A_MUL + int'(w_f3)] = 1'b1;
                    end
`endif
                    default: w_ill = 1'b1;
                endcase
            end
            7'b1110011: w_ill = !(w_inst == 32'h0000_0073 || w_inst == 32'h0010_0073);
            default:    w_ill = 1'b1;
        endcase
        if (w_ill) begin
            w_alu = '0; w_bru = '0; w_lsu = '0; w_src1 = '0; w_src2 = 1'b0; w_rfres = '0; w_we = 1'b0;
        end
        if (w_inst[11:7] == 5'd0) w_we = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0; r_out_pc <= '0; r_out_rs1 <= '0; r_out_rs2 <= '0; r_out_rd <= '0;
            r_out_imm <= '0; r_out_src1 <= '0; r_out_src2 <= 1'b0; r_out_alu <= '0; r_out_bru <= '0;
            r_out_lsu <= '0; r_out_rfres <= '0; r_out_we <= 1'b0; r_out_ill <= 1'b0;
        end else if (bus.flush) begin
            r_out_valid <= 1'b0;
        end else if (w_pop) begin
            r_out_valid <= 1'b1;
            r_out_pc    <= r_pc_q[r_rd_ptr];
            r_out_rs1   <= w_inst[19:15];
            r_out_rs2   <= w_inst[24:20];
            r_out_rd    <= w_inst[11:7];
            r_out_imm   <= w_imm;
            r_out_src1  <= w_src1;
            r_out_src2  <= w_src2;
            r_out_alu   <= w_alu;
            r_out_bru   <= w_bru;
            r_out_lsu   <= w_lsu;
            r_out_rfres <= w_rfres;
            r_out_we    <= w_we;
            r_out_ill   <= w_ill;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.out_valid      = r_out_valid;
    assign bus.out_pc         = r_out_pc;
    assign bus.out_rs1        = r_out_rs1;
    assign bus.out_rs2        = r_out_rs2;
    assign bus.out_rd         = r_out_rd;
    assign bus.out_imm        = r_out_imm;
    assign bus.out_sel_src1   = r_out_src1;
    assign bus.out_sel_src2   = r_out_src2;
    assign bus.out_alu_op     = r_out_alu;
    assign bus.out_bru_op     = r_out_bru;
    assign bus.out_lsu_op     = r_out_lsu;
    assign bus.out_sel_rf_res = r_out_rfres;
    assign bus.out_rf_we      = r_out_we;
    assign bus.out_illegal    = r_out_ill;
endmodule

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 Parameter XLEN, default 64: datapath width; legal values 32 and 64.
REQ-002 Parameter DEPTH, default 4: instruction queue entries; power of two, at least 2.
REQ-003 Parameter PC_W, default 64: program-counter width.
REQ-004 clock  in  1  sole clock; all state updates on the rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 flush  in  1  discards all queued and output-stage instructions.
REQ-007 in_valid  in  1  fetch offers an instruction.
REQ-008 in_ready  out  1  queue accepts an instruction.
REQ-009 in_pc  in  PC_W  pc of the offered instruction.
REQ-010 in_inst  in  32  offered instruction word.
REQ-011 out_valid  out  1  the decoded bundle is valid.
REQ-012 out_ready  in  1  the execute stage consumes the bundle.
REQ-013 out_pc  out  PC_W  pc of the decoded instruction.
REQ-014 out_rs1, out_rs2, out_rd  out  5 each  register indices.
REQ-015 out_imm  out  XLEN  sign-extended immediate, or zero-extended shift amount.
REQ-016 out_sel_src1  out  2  bit0 selects pc (auipc); bit1 selects zero (lui).
REQ-017 out_sel_src2  out  1  selects the immediate as operand 2.
REQ-018 out_alu_op  out  15, or 23 with the M extension  one-hot ALU operation.
REQ-019 out_bru_op  out  8  one-hot {jal, jalr, beq, bne, blt, bge, bltu, bgeu}.
REQ-020 out_lsu_op  out  7  {en, we, size[3:0] as b/h/w/d, unsigned}.
REQ-021 out_sel_rf_res  out  2  bit0 selects the branch unit; bit1 selects the load/store unit.
REQ-022 out_rf_we  out  1  register-file write enable.
REQ-023 out_illegal  out  1  the instruction is not supported in this configuration.

Function
REQ-024 Storage: a circular queue of DEPTH entries holding {pc, inst}, with write pointer, read pointer and occupancy count of log2(DEPTH)+1 bits.
REQ-025 Push: occurs when in_valid and in_ready are both high; in_ready = (count != DEPTH) and does not depend on out_ready.
REQ-026 Full queue: no same-cycle push on a pop; in_ready stays low while count == DEPTH.
REQ-027 Pointer wrap: pointers wrap modulo DEPTH with no lost or duplicated entry.
REQ-028 Output stage: one register stage holding the decoded bundle.
- Loads the decode of the queue head when count > 0 and (out_valid is low or out_ready is high); this pops the head.
- Otherwise holds every out_* value unchanged while out_valid and !out_ready.
REQ-029 Latency: an instruction pushed at edge k into an empty queue with a free output stage drives out_valid high after edge k+1; sustained throughput is 1 instruction per cycle.
REQ-030 Decode: combinational from the head entry, covering RV64I/RV32I base integer ops, loads, stores, branches, jal, jalr, lui, auipc, ecall and ebreak, with field encodings as in REQ-016 to REQ-021.
REQ-031 Immediates: I/S/B/U/J forms sign-extended to XLEN; the shift amount is 6 bits when XLEN=64 and 5 bits for W-forms and when XLEN=32.
REQ-032 Illegal instructions when XLEN=32: W-ops, ld, lwu, sd, and shifts with inst[25]=1.
REQ-033 Illegal instructions always: unknown opcode, funct3 or funct7.
REQ-034 Illegal bundle: out_illegal=1, out_rf_we=0, all op vectors zero, out_pc valid; it is still handshaked normally.
REQ-035 rd=x0: out_rf_we is forced to 0.
REQ-036 Flush: at the edge where flush is high, count, both pointers and out_valid are cleared; an in handshake in the same cycle is dropped; in_ready is high the next cycle.
REQ-037 Flush with out_ready: flush overrides a simultaneous out_ready; the consumer must ignore out_valid in the flush cycle.

Reset
REQ-038 When reset_n is low, the following clear immediately, independent of clock:
- count, pointers, out_valid, out_illegal, out_rf_we;
- all op vectors, out_pc, out_imm, out_rs1, out_rs2, out_rd and both select fields.
REQ-039 Deassertion: after reset_n deasserts, in_ready=1 and out_valid=0 until the first push; reset mid-stream discards all queued entries.

Configuration
REQ-040 Macro RV_M_EXT_EN.
- Defined: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU (funct7=0000001) decode onto out_alu_op[22:15]; their W-forms set the same bits when XLEN=64; out_alu_op is 23 bits wide.
- Undefined: those encodings raise out_illegal, and out_alu_op is 15 bits wide.

Verification
REQ-041 Reset, then push addi x1,x0,5 (0x00500093) at pc 0x80000000 -> after 2 edges out_valid=1, out_imm=5, out_rf_we=1, out_sel_src2=1, add bit set.
REQ-042 Hold out_ready=0 and push 5 instructions with DEPTH=4 -> 1 in the output stage plus 4 queued, in_ready=0, 6th not accepted; release out_ready -> 5 bundles in push order on consecutive cycles.
REQ-043 Push 3 entries, assert flush with in_valid high -> next cycle count=0, out_valid=0, in_ready=1; the flush-cycle instruction never appears.
REQ-044 XLEN=32: push ld x2,0(x1) (0x0000B103) -> out_illegal=1, out_rf_we=0, lsu_op=0.
REQ-045 Push mul x3,x1,x2 (0x022081B3) -> with RV_M_EXT_EN, the mul bit is set and out_illegal=0; without it, out_illegal=1.
REQ-046 Push add x0,x1,x2 (0x00208033) -> out_rf_we=0, out_illegal=0.
